// File: rtl/hc8_regfile_if.sv
// Operand/flag bus between the HC8 register file and the ALU-side controller.
// The regfile is the slave: it serves reads and captures the ALU result and flags.
interface hc8_regfile_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16
);
    localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SEL_W-1:0] rd_a_sel;
    logic [SEL_W-1:0] rd_b_sel;
    logic [WIDTH-1:0] out_A;
    logic [WIDTH-1:0] out_B;
    logic             wr_en;
    logic [SEL_W-1:0] wr_sel;
    logic [WIDTH-1:0] wr_data;
    logic [2:0]       alu_sel;
    logic             alu_carry;
    logic             carry_flag;
    logic             zero_flag;

    modport master (
        output rd_a_sel, rd_b_sel, wr_en, wr_sel, wr_data, alu_sel, alu_carry,
        input  out_A, out_B, carry_flag, zero_flag
    );

    modport slave (
        input  rd_a_sel, rd_b_sel, wr_en, wr_sel, wr_data, alu_sel, alu_carry,
        output out_A, out_B, carry_flag, zero_flag
    );
endinterface

// File: rtl/hc8_regfile.sv
// HC8 operand register file with carry/zero flags, closing the ALU accumulate
// and carry-chain loop across cycles. Two combinational reads, one registered write.
module hc8_regfile #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16
) (
    input logic           clk,
    input logic           rst,
    hc8_regfile_if.slave  bus
);
    localparam int  SEL_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit  POW2   = ((1 << SEL_W) == DEPTH);

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    logic [WIDTH-1:0] regs [DEPTH];
    logic             carry_q;
    logic             zero_q;

    // Index bits beyond DEPTH wrap around instead of addressing missing entries.
    function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] sel);
        if (POW2) begin
            return sel;
        end
        return SEL_W'(int'(sel) % DEPTH);
    endfunction

    // Only arithmetic ops own the carry; logical ops must not disturb a pending chain.
    function automatic logic updates_carry(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic is_zero(input logic [WIDTH-1:0] d);
        return (d == '0);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (bus.wr_en) begin
            regs[wrap_idx(bus.wr_sel)] <= bus.wr_data;
            zero_q <= is_zero(bus.wr_data);
            if (updates_carry(bus.alu_sel)) begin
                carry_q <= bus.alu_carry;
            end
        end
    end

    // Reads see stored state only, so a same-cycle write returns the old value.
    assign bus.out_A      = regs[wrap_idx(bus.rd_a_sel)];
    assign bus.out_B      = regs[wrap_idx(bus.rd_b_sel)];
    assign bus.carry_flag = carry_q;
    assign bus.zero_flag  = zero_q;

endmodule
